serial_right_shifter: RTL and testbench
=======================================

# serial_right_shifter

Multi-cycle 32-bit right shifter for the processor's SRL/SRA/SRLI/SRAI path. It performs the shift in the opposite direction to the single-bit left shifter used in branch-offset and immediate generation. The block shifts one bit per clock under a start/done handshake, so the execute stage can stall on `busy` instead of instantiating a full barrel shifter. It sits beside the ALU and is selected by the ALU-control decode for shift-right opcodes.

## Interface
- `WIDTH`, default 32: data width. Only 32 is supported.
- `SHW`, default 5: shift-amount width, equal to log2(WIDTH).

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a shift. Accepted only while `busy`=0.
- `data_in` input WIDTH: operand (rs1). Sampled on the accepting edge.
- `shamt` input SHW: shift amount (rs2[4:0] or imm[4:0]). Sampled on the accepting edge.
- `arith` input 1: 1 selects arithmetic (sign-fill), 0 selects logical (zero-fill). Sampled on the accepting edge.
- `dir` input 1: 1 selects left shift. Used only when `LEFT_SHIFT_EN` is defined (see Configuration).
- `busy` output 1: high from the cycle after acceptance until `done` has been given.
- `done` output 1: one-cycle pulse; `result` is valid during it.
- `result` output WIDTH: shifted value. Held until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE. `busy` = (state != IDLE).
- IDLE with `start`=1 (accepting edge):
  - Load the shift register with `data_in`.
  - Load the counter with `shamt`.
  - Latch `arith` and `dir`.
  - Next state is SHIFT if `shamt`!=0, otherwise DONE.
- SHIFT, on each edge:
  - Logical: reg <= {1'b0, reg[31:1]}.
  - Arithmetic: reg <= {reg[31], reg[31:1]}.
  - Counter decrements by 1. When the counter equals 1 before the edge, next state is DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `result` is driven directly from the shift register.
- `start` while `busy`=1 (SHIFT or DONE) is ignored. Operands are not re-sampled and no queueing occurs.
- The sign bit for arithmetic mode is taken from the latched operand's bit 31, which is held fixed by the fill rule.
- Inputs changing after the accepting edge have no effect on the operation in flight.
- Reset, including mid-operation: state is IDLE; `busy`=0, `done`=0, `result`=32'h0. The counter and latched flags are cleared. No `done` is produced for the aborted operation.

## Timing
- Label the accepting edge E0.
- `done` is high in the cycle after edge E(shamt). Total latency from start is shamt+1 cycles.
  - shamt=0: `done` in the cycle right after E0.
  - shamt=31: `done` in the cycle after E31.
- `busy` rises after E0 and falls after the edge that ends DONE.
- The next `start` can be accepted at the edge ending DONE+1, i.e. the first cycle in which `busy`=0.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

## Configuration
- `LEFT_SHIFT_EN` defined:
  - The latched `dir`=1 performs logical left shifts (reg <= {reg[30:0], 1'b0}) in SHIFT. `arith` is ignored when `dir`=1.
  - The block then also serves SLL/SLLI, with the same latency and handshake.
- `LEFT_SHIFT_EN` undefined:
  - `dir` is unused and the block is right-shift only.
  - Left shifts remain on the existing combinational path.

## Test plan
- Reset asserted then released: `busy`=0, `done`=0, `result`=0x00000000. Idle cycles with `start`=0 produce no `done`.
- Logical, `data_in`=0x80000000, shamt=31, arith=0: `done` after 32 cycles, `result`=0x00000001; `busy` high for exactly 32 cycles.
- Arithmetic, `data_in`=0x80000000, shamt=4, arith=1: `result`=0xF8000000 with `done` in the 5th cycle. With arith=0 the same operand gives `result`=0x08000000.
- shamt=0, `data_in`=0xDEADBEEF: `done` in the cycle after start, `result`=0xDEADBEEF. A second `start` pulsed during DONE is ignored, with no second `done`.
- Start shamt=10, then assert `rst` at cycle 5: outputs return to their reset values immediately. After release, a new start with 0x0000F000, shamt=12 gives `result`=0x0000000F.
- With `LEFT_SHIFT_EN` defined, dir=1, `data_in`=0x00000001, shamt=31: `result`=0x80000000 after 32 cycles. Without the macro, the same stimulus gives 0x00000000 (a right shift).

Source files
------------

// File: rtl/serial_right_shifter.sv
// Multi-cycle shifter: one bit per clock under a start/done handshake, right shifts (logical/arithmetic).
// Optional macro LEFT_SHIFT_EN adds logical left shifts selected by the latched dir input.
module serial_right_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_n_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_n_s;
  logic [WIDTH-1:0] step_s;
  logic [SHW-1:0]   count_r;
  logic [SHW-1:0]   count_n_s;
  logic             arith_r;
  logic             arith_n_s;

`ifdef LEFT_SHIFT_EN
  logic             dir_r;
  logic             dir_n_s;

  // One-bit step of the shift register; left shifts ignore the arithmetic flag.
  always_comb begin
    step_s = shreg_r;
    if (dir_r) begin
      step_s = {shreg_r[WIDTH-2:0], 1'b0};
    end else if (arith_r) begin
      step_s = {shreg_r[WIDTH-1], shreg_r[WIDTH-1:1]};
    end else begin
      step_s = {1'b0, shreg_r[WIDTH-1:1]};
    end
  end
`else
  logic             dir_unused_s;

  assign dir_unused_s = dir;

  // One-bit right step; the sign bit refills itself, so it stays the operand's original bit.
  always_comb begin
    step_s = shreg_r;
    if (arith_r) begin
      step_s = {shreg_r[WIDTH-1], shreg_r[WIDTH-1:1]};
    end else begin
      step_s = {1'b0, shreg_r[WIDTH-1:1]};
    end
  end
`endif

  // Next-state logic: accept only in IDLE, count down in SHIFT, single-cycle DONE.
  always_comb begin
    state_n_s = state_r;
    shreg_n_s = shreg_r;
    count_n_s = count_r;
    arith_n_s = arith_r;
`ifdef LEFT_SHIFT_EN
    dir_n_s   = dir_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_n_s = data_in;
          count_n_s = shamt;
          arith_n_s = arith;
`ifdef LEFT_SHIFT_EN
          dir_n_s   = dir;
`endif
          if (shamt != CNT_ZERO) begin
            state_n_s = SHIFT;
          end else begin
            state_n_s = DONE;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      SHIFT: begin
        shreg_n_s = step_s;
        count_n_s = count_r - CNT_ONE;
        if (count_r == CNT_ONE) begin
          state_n_s = DONE;
        end else begin
          state_n_s = SHIFT;
        end
      end
      DONE: begin
        state_n_s = IDLE;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      count_r <= CNT_ZERO;
      arith_r <= 1'b0;
`ifdef LEFT_SHIFT_EN
      dir_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n_s;
      shreg_r <= shreg_n_s;
      count_r <= count_n_s;
      arith_r <= arith_n_s;
`ifdef LEFT_SHIFT_EN
      dir_r   <= dir_n_s;
`endif
    end
  end

  assign busy   = (state_r != IDLE);
  assign done   = (state_r == DONE);
  assign result = shreg_r;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Scoreboard bench for serial_right_shifter: driver pushes expected results, monitor pops on done.
module tb_serial_right_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          sh;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          cyc;
  int          busy_run;
  logic [31:0] last_res;

  serial_right_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .shamt(shamt),
    .arith(arith), .dir(dir), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain shift operators on the whole operand.
  function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic ar, input logic dr);
`ifdef LEFT_SHIFT_EN
    if (dr) return d << sh;
`endif
    if (ar) return $unsigned($signed(d) >>> sh);
    return d >> sh;
  endfunction

  // Monitor: compare on done, track busy length and result hold while idle.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
      last_res = 32'h0;
    end else begin
      if (busy) busy_run = busy_run + 1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("done_cycle", cyc, e.cyc);
          check("busy_len", busy_run, e.sh + 1);
          last_res = e.res;
        end
      end
      if (!busy) begin
        if (busy_run != 0 && !done) busy_run = 0;
        check("result_hold", result, last_res);
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [31:0] d, input logic [4:0] sh, input logic ar, input logic dr,
                       input bit pulse_busy, input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1; data_in = d; shamt = sh; arith = ar; dir = dr;
    @(posedge clk);
    #1;
    e.res = model(d, int'(sh), ar, dr);
    e.sh  = int'(sh);
    e.cyc = cyc + int'(sh);
    if (push) sb.push_back(e);
    start = 1'b0; data_in = $urandom; shamt = 5'($urandom); arith = 1'($urandom); dir = 1'($urandom);
    if (pulse_busy) begin
      @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; busy_run = 0; last_res = 32'h0;
    rst = 1'b1; start = 1'b0; data_in = 32'h0; shamt = 5'd0; arith = 1'b0; dir = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_op(32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(32'h8000_0000, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1);
    do_op(32'h8000_0000, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1);
    do_op(32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1);
    do_op(32'h0000_0001, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1);

    // Abort mid-operation: no done may follow, outputs clear at once.
    wait_idle();
    start = 1'b1; data_in = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b1; dir = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h0000_F000, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
